// File: rtl/rr_arbiter4.sv
// rr_arbiter4 -- four-way round-robin arbiter with a hold-time watchdog.
//
// Shares one resource between four requesters. A grant is held until the
// owner raises done, drops its request, or the hold counter reaches
// TIMEOUT_CYCLES. A forced release raises timeout for one cycle. Every
// release is followed by at least one idle cycle before the next grant, so
// a downstream decoder never switches owner inside one cycle.
//
// Handshake: req[i] is a level request. It is not latched. It is evaluated
// only in IDLE, and only the owner's bit is watched during GRANT. done is
// sampled only while grantValid=1.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   req[3:0]   request lines
//   done       owner finished
//   grant[3:0] registered one-hot grant, zero when idle
//   grantIdx   encoded owner index, holds last owner while idle
//   grantValid high exactly when grant is nonzero
//   timeout    one-cycle pulse on watchdog revocation
//   dbg_state  current FSM state (0=IDLE, 1=GRANT)
//   dbg_ptr    current highest-priority requester
module rr_arbiter4 #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] grantIdx,
  output logic       grantValid,
  output logic       timeout,
  output logic       dbg_state,
  output logic [1:0] dbg_ptr
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  state_t           state, state_n;
  logic [1:0]       ptr, ptr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       grant_n;
  logic [1:0]       idx_n;
  logic             valid_n;
  logic             timeout_n;

  // First set request bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  logic       found;
  logic [1:0] sel;
  logic [1:0] probe;

  always_comb begin
    found = 1'b0;
    sel   = 2'b00;
    probe = 2'b00;
    for (int k = 0; k < 4; k++) begin
      probe = ptr + 2'(k);
      if (!found && req[probe]) begin
        found = 1'b1;
        sel   = probe;
      end
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cnt_n     = cnt;
    grant_n   = grant;
    idx_n     = grantIdx;
    valid_n   = grantValid;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          grant_n = 4'b0001 << sel;
          idx_n   = sel;
          valid_n = 1'b1;
          cnt_n   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (done || !req[grantIdx] || (cnt == TMO)) begin
          state_n = IDLE;
          grant_n = 4'b0000;
          valid_n = 1'b0;
          ptr_n   = grantIdx + 2'd1;
          // done and a dropped request take precedence over the watchdog.
          timeout_n = !(done || !req[grantIdx]);
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= 2'b00;
      cnt        <= '0;
      grant      <= 4'b0000;
      grantIdx   <= 2'b00;
      grantValid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      cnt        <= cnt_n;
      grant      <= grant_n;
      grantIdx   <= idx_n;
      grantValid <= valid_n;
      timeout    <= timeout_n;
    end
  end

  assign dbg_state = state;
  assign dbg_ptr   = ptr;

endmodule
